// File: rtl/weight_fetch_seq.sv
// Weight ROM read initiator: strobes one word per fetch and
// streams captured weights through a small output FIFO.
module weight_fetch_seq #(
  parameter int FIFO_DEPTH = 2,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_add,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] add,
  output logic          CS,
  output logic          cen,
  input  logic [DW-1:0] Wkp,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          w_last,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] rem;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          lst [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  logic s_idle;
  logic s_setup;
  logic s_strobe;
  logic s_drain;
  logic push;
  logic pop;
  logic room;

  assign s_idle   = (state == IDLE);
  assign s_setup  = (state == SETUP);
  assign s_strobe = (state == STROBE);
  assign s_drain  = (state == DRAIN);

  // Nothing is in flight outside STROBE, so occupancy alone gates it.
  assign room = (cnt < CW'(FIFO_DEPTH));
  assign push = s_strobe;
  assign pop  = w_valid & w_ready;

  assign w_valid = (cnt != '0);
  assign w_data  = w_valid ? mem[rp] : '0;
  assign w_last  = w_valid & lst[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      add   <= '0;
      rem   <= '0;
      CS    <= 1'b0;
      cen   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cen  <= 1'b1;
      done <= 1'b0;
      unique case (1'b1)
        s_idle: begin
          if (start && cen) begin
            add   <= base_add;
            rem   <= len;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        s_setup: begin
          if (room) begin
            CS    <= 1'b1;
            state <= STROBE;
          end
        end
        s_strobe: begin
          CS <= 1'b0;
          if (rem == '0) begin
            state <= DRAIN;
          end else begin
            add   <= add + AW'(1);
            rem   <= rem - AW'(1);
            state <= SETUP;
          end
        end
        s_drain: begin
          // Only the tail word carries the last flag here.
          if (pop && lst[rp]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= Wkp;
      lst[wp] <= (rem == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/weight_fetch_seq.md
Name: weight_fetch_seq

Overview:
- Read initiator for the 8-bit weight ROM (Wk port set: add, CS, cen, Wkp).
- Given a base address and a word count, it drives the ROM address and a CS strobe for each word and captures Wkp.
- It streams the captured weights to the downstream MAC/scoring datapath over a valid/ready interface, through a 2-entry output FIFO, so ROM fetches continue while the consumer stalls.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; fixed power of two, 2 is the only supported value.
- AW, 8, ROM address width.
- DW, 8, weight width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_add  in  8  first ROM address of the burst.
- len  in  8  burst length minus one (0 means 1 word, 255 means 256 words).
- add  out  8  ROM address; registered.
- CS  out  1  ROM read strobe; registered; ROM captures on its rising edge.
- cen  out  1  ROM enable, active-low clear; registered.
- Wkp  in  8  ROM read data.
- w_data  out  8  weight to consumer; FIFO head.
- w_valid  out  1  w_data valid.
- w_ready  in  1  consumer accepts when w_valid and w_ready are both high.
- w_last  out  1  high with the final word of a burst.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last word handshakes.

Behaviour:
- Reset, every output for the cycle after rst is sampled high:
  - add=0, CS=0, cen=0, w_valid=0, w_last=0, busy=0, done=0, w_data=0.
  - FIFO is emptied; the word counter is cleared; the FSM goes to IDLE.
- cen behaviour:
  - cen stays 0 while rst is high, which clears the ROM output.
  - cen goes to 1 on the first clk after rst deasserts.
  - start is ignored until cen=1.
- FSM states:
  - IDLE: on start, latch base_add into the address counter and len into the remaining counter, set busy=1, go to SETUP.
  - SETUP: add is driven to the current address with CS=0. If FIFO occupancy plus in-flight words is less than 2, go to STROBE; otherwise stay in SETUP with CS held 0.
  - STROBE: CS=1 for exactly one cycle with add held stable. At the end of the cycle, Wkp is written into the FIFO with last flag = (remaining==0).
    - If remaining==0, go to DRAIN.
    - Otherwise increment add modulo 256 (0xFF wraps to 0x00), decrement remaining, go to SETUP.
  - DRAIN: wait until the FIFO is empty and the last word has handshaked. Then pulse done=1, clear busy, go to IDLE.
- Throughput:
  - One ROM word per 2 clk cycles when the consumer is ready.
  - First w_valid appears 3 cycles after start is sampled: SETUP, STROBE, then FIFO visible.
- CS never rises while add is changing; add changes only on the edge that leaves STROBE.
- FIFO:
  - A write and a read in the same cycle are both honoured.
  - On full: STROBE is never entered, so no write is ever dropped.
  - On empty: w_valid=0.
  - w_data and w_last are stable while w_valid=1 and w_ready=0.
- start while busy is ignored: no relatch, no effect on the current burst.
- A burst of 256 words (len=255) visits each address exactly once, ending at base_add-1 mod 256.
- done and w_last never assert outside a burst.
- done asserts the cycle after the last-word handshake; start may be accepted in the same cycle done is high (FSM in IDLE).
- Reset mid-burst:
  - The burst is abandoned and the FIFO contents are discarded.
  - No done pulse is produced.
  - The outputs match the reset values in the first cycle after rst is sampled high.

Test Plan:
- Reset release then start, base_add=0x00, len=3, w_ready=1:
  - w_data sequence 0x00, 0x02, 0x02, 0x02, with w_last only on the 4th word.
  - CS pulses 4 times at add 0,1,2,3.
  - done pulses once; busy falls with done.
- Wrap-around, base_add=0xFE, len=3:
  - add sequence 0xFE, 0xFF, 0x00, 0x01.
  - w_data sequence 0x02, 0x02, 0x00, 0x02.
  - done pulses once.
- Backpressure, base_add=0x00, len=7, w_ready=0 for the first 12 cycles then 1:
  - Exactly 2 CS pulses occur before w_ready rises; FIFO holds 0x00, 0x02; w_data stays 0x00 throughout the stall.
  - After release, 8 words delivered in order, no loss or duplication, w_last on the 8th word.
- Full burst, base_add=0x80, len=255:
  - 256 handshakes; addresses 0x80..0xFF then 0x00..0x7F, each exactly once.
  - Exactly one w_data=0x00, at the 129th word.
- start pulsed again at cycle 4 of a len=3 burst:
  - Burst unchanged, 4 words, a single done; a start pulsed after done begins a fresh burst.
- rst asserted during the STROBE of word 3 of a len=5 burst:
  - Next cycle: CS=0, cen=0, w_valid=0, busy=0, no done.
  - After release: cen=1 next cycle, and a new start at base_add=0x00, len=0 returns the single word 0x00 with w_last=1.
